// File: rtl/score_display_mux.sv
// Scans a 4-digit BCD score onto a common-anode seven-segment display.
// Score is snapshotted once per frame, leading zeros can be blanked, and the display can blink.
module score_display_mux #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1,
  parameter int BLINK_FRAMES  = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] points_3,
  input  logic [3:0] points_2,
  input  logic [3:0] points_1,
  input  logic [3:0] points_0,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_FRAMES) + 1;

  logic [DW-1:0] div_cnt;
  logic [1:0]    sel;
  logic [3:0]    shadow [4];
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic          tick;
  logic          snap;
  logic          lead_zero;
  logic          blanked;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign tick = (div_cnt == DW'(REFRESH_DIV - 1));
  assign snap = tick && (sel == 2'd3);
  assign dp   = 1'b1;

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    lead_zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(sel) && shadow[k] != 4'd0) lead_zero = 1'b0;
    end
    blanked = (BLANK_LEADING != 0) && (sel != 2'd0) && lead_zero;
  end

  // The tick cycle loads an all-off pattern so each slot begins with a dead cycle.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    if (!(tick || (blink_en && blink_phase) || blanked)) begin
      an_next  = ~(4'b0001 << sel);
      seg_next = decode(shadow[sel]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      sel         <= 2'd0;
      for (int k = 0; k < 4; k++) shadow[k] <= 4'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DW'(1);
      if (tick) sel <= sel + 2'd1;
      frame_start <= snap;
      if (snap) begin
        shadow[3] <= points_3;
        shadow[2] <= points_2;
        shadow[1] <= points_1;
        shadow[0] <= points_0;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux: one instance with leading-zero blanking, one without,
// both checked every cycle against a cycle-count based reference model.
module tb_score_display_mux;

  localparam int R  = 4;
  localparam int BF = 2;

  logic       clk;
  logic       rst;
  logic [3:0] points_3, points_2, points_1, points_0;
  logic       blink_en;
  logic [3:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;
  logic       frame_start, frame_start_nb;

  int tests;
  int failed;

  score_display_mux #(.REFRESH_DIV(R), .BLANK_LEADING(1), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .points_3(points_3), .points_2(points_2), .points_1(points_1), .points_0(points_0),
    .blink_en(blink_en), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  score_display_mux #(.REFRESH_DIV(R), .BLANK_LEADING(0), .BLINK_FRAMES(BF)) dut_nb (
    .clk(clk), .rst(rst),
    .points_3(points_3), .points_2(points_2), .points_1(points_1), .points_0(points_0),
    .blink_en(blink_en), .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame_start(frame_start_nb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: state is derived from the number of clock edges since reset
  logic [6:0]  seg_tab [16];
  int          n;
  logic [3:0]  m_sh [4];
  logic [24:0] exp_q [$];

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
  end

  function automatic int phase_now();
    return ((n / (4 * R)) / BF) % 2;
  endfunction

  task automatic model_edge();
    int         slot_pos, digit;
    bit         tick, dark, lz, fs;
    logic [3:0] on_an, a1, a0;
    logic [6:0] s1, s0;
    if (rst) begin
      n = 0;
      for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
      exp_q.push_back({1'b0, 1'b1, 1'b0, 4'hF, 7'h7F, 4'hF, 7'h7F});
    end else begin
      slot_pos = n % R;
      digit    = (n / R) % 4;
      tick     = (slot_pos == R - 1);
      dark     = blink_en && (phase_now() == 1);
      lz       = 1'b1;
      for (int k = digit; k < 4; k++) if (m_sh[k] != 0) lz = 1'b0;
      on_an = ~(4'b0001 << digit);
      a1 = (tick || dark || (digit != 0 && lz)) ? 4'hF : on_an;
      a0 = (tick || dark) ? 4'hF : on_an;
      s1 = (a1 == 4'hF) ? 7'h7F : seg_tab[m_sh[digit]];
      s0 = (a0 == 4'hF) ? 7'h7F : seg_tab[m_sh[digit]];
      fs = tick && (digit == 3);
      exp_q.push_back({fs, 1'b1, fs, a1, s1, a0, s0});
      if (fs) begin
        m_sh[3] = points_3; m_sh[2] = points_2; m_sh[1] = points_1; m_sh[0] = points_0;
      end
      n++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t n=%0d", tag, got, exp, $time, n);
    end
  endtask

  // scoreboard: one expected vector per clock edge
  task automatic compare();
    logic [24:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("frame_start",    {31'd0, frame_start},    {31'd0, e[24]});
      check("dp",             {31'd0, dp},             {31'd0, e[23]});
      check("frame_start_nb", {31'd0, frame_start_nb}, {31'd0, e[22]});
      check("an",             {28'd0, an},             {28'd0, e[21:18]});
      check("seg",            {25'd0, seg},            {25'd0, e[17:11]});
      check("an_nb",          {28'd0, an_nb},          {28'd0, e[10:7]});
      check("seg_nb",         {25'd0, seg_nb},         {25'd0, e[6:0]});
      check("dp_nb",          {31'd0, dp_nb},          32'd1);
    end
  endtask

  // driver tasks
  task automatic cyc(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic set_points(input logic [3:0] d3, d2, d1, d0);
    points_3 = d3; points_2 = d2; points_1 = d1; points_0 = d0;
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 3) == 0) return 4'd0;
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    int k;
    tests = 0; failed = 0; n = 0;
    rst = 1'b1; blink_en = 1'b0;
    set_points(0, 0, 0, 0);

    // reset, all-zero score
    cyc(3);
    rst = 1'b0;
    cyc(20);

    // 1234
    set_points(1, 2, 3, 4);
    cyc(40);

    // load 0507, then change to 9999 mid-frame
    set_points(0, 5, 0, 7);
    k = 0;
    while (n % 16 != 1 && k < 40) begin cyc(1); k++; end
    check("sync_frame", {31'd0, (n % 16 == 1)}, 32'd1);
    cyc(5);
    set_points(9, 9, 9, 9);
    cyc(40);

    // interior zero below a leading zero run
    set_points(0, 0, 4, 0);
    cyc(40);

    // blink, then release while dark
    blink_en = 1'b1;
    cyc(80);
    k = 0;
    while (phase_now() == 0 && k < 64) begin cyc(1); k++; end
    check("reach_dark", phase_now(), 32'd1);
    cyc(3);
    blink_en = 1'b0;
    cyc(12);

    // dash code, then reset mid-frame
    set_points(1, 2, 4'hC, 3);
    cyc(36);
    cyc($urandom_range(1, 15));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(20);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      set_points(rand_digit(), rand_digit(), rand_digit(), rand_digit());
      blink_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(5, 40));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
